// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the ROB store-commit port /
// load buffer and an 8-bit single-port RAM (1-cycle read latency), little-endian.
// Optional build macro MEMCTRL_IO_STALL_EN: stores into the IO window stall
// while the UART output buffer reports full.
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 4
`endif
`ifndef LB
`define LB  4'd0
`endif
`ifndef LH
`define LH  4'd1
`endif
`ifndef LW
`define LW  4'd2
`endif
`ifndef LBU
`define LBU 4'd3
`endif
`ifndef LHU
`define LHU 4'd4
`endif
`ifndef SB
`define SB  4'd5
`endif
`ifndef SH
`define SH  4'd6
`endif
`ifndef SW
`define SW  4'd7
`endif

module mem_ctrl #(
  parameter int         ROB_TAG_W  = 5,
  parameter logic [1:0] IO_HI_BITS = 2'b11
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        flush_in,
  input  logic                        rob_en_in,
  input  logic [31:0]                 rob_address_in,
  input  logic [31:0]                 rob_wdata_in,
  input  logic [`INST_TYPE_WIDTH-1:0] rob_inst_type_in,
  output logic                        rob_rdy_out,
  output logic                        rob_finish_out,
  input  logic                        lbuffer_en_in,
  input  logic [31:0]                 lbuffer_address_in,
  input  logic [`INST_TYPE_WIDTH-1:0] lbuffer_inst_type_in,
  input  logic [ROB_TAG_W-1:0]        lbuffer_dest_in,
  output logic                        lbuffer_rdy_out,
  output logic                        lbuffer_finish_out,
  output logic [ROB_TAG_W-1:0]        lbuffer_dest_out,
  output logic [31:0]                 lbuffer_value_out,
  input  logic [7:0]                  mem_din_in,
  output logic [7:0]                  mem_dout_out,
  output logic [31:0]                 mem_a_out,
  output logic                        mem_wr_out,
  input  logic                        io_buffer_full_in
);
  typedef enum logic [1:0] {IDLE = 2'd0, STORE = 2'd1, LOAD = 2'd2} state_t;

  state_t                      state, state_nx;
  // STORE: cnt = next byte to write, flag = last byte already written.
  // LOAD:  cnt = lane to capture,   flag = first RAM read already in flight.
  logic [1:0]                  cnt, cnt_nx;
  logic                        flag, flag_nx;
  logic [31:0]                 addr, addr_nx, wdata, wdata_nx, lanes, lanes_nx;
  logic [`INST_TYPE_WIDTH-1:0] itype, itype_nx;
  logic [ROB_TAG_W-1:0]        tag, tag_nx, dest_nx;
  logic                        rob_finish_nx, lb_finish_nx, wr_nx;
  logic [7:0]                  dout_nx;
  logic [31:0]                 a_nx, value_nx;
  logic                        stall_new, stall_cur;

  // Index of the final byte of an access: 0/1/3 for byte/half/word.
  function automatic logic [1:0] last_idx(input logic [`INST_TYPE_WIDTH-1:0] t);
    case (t)
      `LB, `LBU, `SB: last_idx = 2'd0;
      `LH, `LHU, `SH: last_idx = 2'd1;
      default:        last_idx = 2'd3;
    endcase
  endfunction

  // Sign- or zero-extend the assembled little-endian load data.
  function automatic logic [31:0] extend(input logic [`INST_TYPE_WIDTH-1:0] t,
                                         input logic [31:0] raw);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = raw[7:0];
    h = raw[15:0];
    case (t)
      `LB:     extend = 32'(b);
      `LH:     extend = 32'(h);
      `LBU:    extend = {24'd0, raw[7:0]};
      `LHU:    extend = {16'd0, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

`ifdef MEMCTRL_IO_STALL_EN
  assign stall_new = (rob_address_in[17:16] == IO_HI_BITS) && io_buffer_full_in;
  assign stall_cur = (addr[17:16] == IO_HI_BITS) && io_buffer_full_in;
`else
  logic io_unused;
  assign io_unused = io_buffer_full_in ^ (^IO_HI_BITS);
  assign stall_new = 1'b0;
  assign stall_cur = 1'b0;
`endif

  assign rob_rdy_out     = (state == IDLE);
  assign lbuffer_rdy_out = (state == IDLE);

  // Next-state and next-output computation for every register.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    flag_nx       = flag;
    addr_nx       = addr;
    wdata_nx      = wdata;
    lanes_nx      = lanes;
    itype_nx      = itype;
    tag_nx        = tag;
    rob_finish_nx = 1'b0;
    lb_finish_nx  = 1'b0;
    wr_nx         = mem_wr_out;
    dout_nx       = mem_dout_out;
    a_nx          = mem_a_out;
    value_nx      = lbuffer_value_out;
    dest_nx       = lbuffer_dest_out;
    case (state)
      IDLE: begin
        if (rob_en_in) begin
          addr_nx  = rob_address_in;
          wdata_nx = rob_wdata_in;
          itype_nx = rob_inst_type_in;
          cnt_nx   = 2'd0;
          flag_nx  = 1'b0;
          state_nx = STORE;
          a_nx     = rob_address_in;
          wr_nx    = 1'b0;
          // Byte 0 goes out on the acceptance edge unless the IO window is full.
          if (!stall_new) begin
            dout_nx = rob_wdata_in[7:0];
            wr_nx   = 1'b1;
            if (last_idx(rob_inst_type_in) == 2'd0) flag_nx = 1'b1;
            else                                    cnt_nx  = 2'd1;
          end
        end else if (lbuffer_en_in && !flush_in) begin
          addr_nx  = lbuffer_address_in;
          itype_nx = lbuffer_inst_type_in;
          tag_nx   = lbuffer_dest_in;
          cnt_nx   = 2'd0;
          flag_nx  = 1'b0;
          state_nx = LOAD;
          a_nx     = lbuffer_address_in;
          wr_nx    = 1'b0;
        end
      end
      STORE: begin
        if (flag) begin
          rob_finish_nx = 1'b1;
          wr_nx         = 1'b0;
          state_nx      = IDLE;
        end else if (stall_cur) begin
          wr_nx = 1'b0;
        end else begin
          a_nx    = addr + 32'(cnt);
          dout_nx = wdata[{cnt, 3'b000} +: 8];
          wr_nx   = 1'b1;
          if (cnt == last_idx(itype)) flag_nx = 1'b1;
          else                        cnt_nx  = cnt + 2'd1;
        end
      end
      LOAD: begin
        wr_nx = 1'b0;
        if (flush_in) begin
          state_nx = IDLE;
        end else if (!flag) begin
          flag_nx = 1'b1;
          if (last_idx(itype) != 2'd0) a_nx = mem_a_out + 32'd1;
        end else begin
          lanes_nx[{cnt, 3'b000} +: 8] = mem_din_in;
          if (cnt == last_idx(itype)) begin
            lb_finish_nx = 1'b1;
            value_nx     = extend(itype, lanes_nx);
            dest_nx      = tag;
            state_nx     = IDLE;
          end else begin
            cnt_nx = cnt + 2'd1;
            // Keep addresses one byte ahead of capture, never past the access.
            if (({1'b0, cnt} + 3'd1) < {1'b0, last_idx(itype)}) a_nx = mem_a_out + 32'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state and registered outputs; reset wins over rdy_in.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= IDLE;
      cnt                <= 2'd0;
      flag               <= 1'b0;
      rob_finish_out     <= 1'b0;
      lbuffer_finish_out <= 1'b0;
      mem_wr_out         <= 1'b0;
      mem_a_out          <= 32'd0;
      mem_dout_out       <= 8'd0;
      lbuffer_value_out  <= 32'd0;
      lbuffer_dest_out   <= '0;
    end else if (rdy_in) begin
      state              <= state_nx;
      cnt                <= cnt_nx;
      flag               <= flag_nx;
      rob_finish_out     <= rob_finish_nx;
      lbuffer_finish_out <= lb_finish_nx;
      mem_wr_out         <= wr_nx;
      mem_a_out          <= a_nx;
      mem_dout_out       <= dout_nx;
      lbuffer_value_out  <= value_nx;
      lbuffer_dest_out   <= dest_nx;
    end
  end

  // Latched request fields and captured load bytes.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      addr  <= addr_nx;
      wdata <= wdata_nx;
      itype <= itype_nx;
      tag   <= tag_nx;
      lanes <= lanes_nx;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a byte-level
// memory model with a 1-cycle-latency RAM attached to the DUT pins.
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 4
`endif
`ifndef LB
`define LB  4'd0
`endif
`ifndef LH
`define LH  4'd1
`endif
`ifndef LW
`define LW  4'd2
`endif
`ifndef LBU
`define LBU 4'd3
`endif
`ifndef LHU
`define LHU 4'd4
`endif
`ifndef SB
`define SB  4'd5
`endif
`ifndef SH
`define SH  4'd6
`endif
`ifndef SW
`define SW  4'd7
`endif

module tb_mem_ctrl;
  localparam int TW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, rdy = 1'b1, flush = 1'b0;
  logic rob_en = 1'b0;
  logic [31:0] rob_addr = '0, rob_wdata = '0;
  logic [`INST_TYPE_WIDTH-1:0] rob_type = '0;
  logic rob_rdy, rob_fin;
  logic lb_en = 1'b0;
  logic [31:0] lb_addr = '0;
  logic [`INST_TYPE_WIDTH-1:0] lb_type = '0;
  logic [TW-1:0] lb_dest = '0;
  logic lb_rdy, lb_fin;
  logic [TW-1:0] lb_dest_o;
  logic [31:0] lb_val;
  logic [7:0] mem_din = '0, mem_dout;
  logic [31:0] mem_a;
  logic mem_wr;
  logic io_full = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_ctrl #(.ROB_TAG_W(TW), .IO_HI_BITS(2'b11)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .rob_en_in(rob_en), .rob_address_in(rob_addr), .rob_wdata_in(rob_wdata),
    .rob_inst_type_in(rob_type), .rob_rdy_out(rob_rdy), .rob_finish_out(rob_fin),
    .lbuffer_en_in(lb_en), .lbuffer_address_in(lb_addr),
    .lbuffer_inst_type_in(lb_type), .lbuffer_dest_in(lb_dest),
    .lbuffer_rdy_out(lb_rdy), .lbuffer_finish_out(lb_fin),
    .lbuffer_dest_out(lb_dest_o), .lbuffer_value_out(lb_val),
    .mem_din_in(mem_din), .mem_dout_out(mem_dout), .mem_a_out(mem_a),
    .mem_wr_out(mem_wr), .io_buffer_full_in(io_full)
  );

  // RAM contents seen by the DUT, and the contents the bench expects.
  logic [7:0] ram   [int unsigned];
  logic [7:0] model [int unsigned];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    logic [31:0] x;
    x = a * 32'd7 + 32'd3;
    return x[7:0];
  endfunction

  function automatic logic [7:0] mget(input logic [31:0] a);
    return model.exists(a) ? model[a] : dflt(a);
  endfunction

  always @(posedge clk) begin
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : dflt(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
    ram[a] = v;
    model[a] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int nbytes(input logic [`INST_TYPE_WIDTH-1:0] t);
    if (t == `SB || t == `LB || t == `LBU) return 1;
    if (t == `SH || t == `LH || t == `LHU) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [`INST_TYPE_WIDTH-1:0] t);
    logic [31:0] v, b0, b1, b2, b3;
    b0 = 32'(mget(a));
    b1 = 32'(mget(a + 32'd1));
    b2 = 32'(mget(a + 32'd2));
    b3 = 32'(mget(a + 32'd3));
    case (t)
      `LB, `LBU: begin
        v = b0;
        if (t == `LB && b0 >= 32'd128) v = v + 32'hFFFFFF00;
      end
      `LH, `LHU: begin
        v = b0 + b1 * 32'd256;
        if (t == `LH && v >= 32'd32768) v = v + 32'hFFFF0000;
      end
      default: v = b0 + b1 * 32'd256 + b2 * 32'd65536 + b3 * 32'd16777216;
    endcase
    return v;
  endfunction

  // Store accepted in the current cycle; ends in the finish cycle.
  task automatic store_run(input logic [31:0] a, input logic [31:0] d,
                           input logic [`INST_TYPE_WIDTH-1:0] t, input int freeze_at);
    int n;
    logic [31:0] eb;
    n = nbytes(t);
    chk("st_rdy_idle", 32'(rob_rdy), 32'd1);
    rob_en = 1'b1; rob_addr = a; rob_wdata = d; rob_type = t;
    tick();
    rob_en = 1'b0;
    chk("st_busy", 32'(rob_rdy), 32'd0);
    chk("st_prev_pulse_clear", 32'({rob_fin, lb_fin}), 32'd0);
    for (int k = 0; k < n; k++) begin
      eb = (d >> (8 * k)) & 32'hFF;
      chk("st_wr", 32'(mem_wr), 32'd1);
      chk("st_addr", mem_a, a + 32'(k));
      chk("st_byte", 32'(mem_dout), eb);
      chk("st_no_fin", 32'({rob_fin, lb_fin}), 32'd0);
      if (k == freeze_at) begin
        rdy = 1'b0;
        repeat (3) begin
          tick();
          chk("frz_wr", 32'(mem_wr), 32'd1);
          chk("frz_addr", mem_a, a + 32'(k));
          chk("frz_byte", 32'(mem_dout), eb);
          chk("frz_no_fin", 32'(rob_fin), 32'd0);
        end
        rdy = 1'b1;
      end
      tick();
    end
    chk("st_fin", 32'(rob_fin), 32'd1);
    chk("st_fin_wr0", 32'(mem_wr), 32'd0);
    chk("st_fin_rdy", 32'(rob_rdy), 32'd1);
    chk("st_fin_no_lbfin", 32'(lb_fin), 32'd0);
    for (int k = 0; k < n; k++) model[a + 32'(k)] = 8'((d >> (8 * k)) & 32'hFF);
  endtask

  // Load accepted in the current cycle. abort_kind 1 = flush, 2 = reset,
  // applied during cycle T+abort_at.
  task automatic load_run(input logic [31:0] a, input logic [`INST_TYPE_WIDTH-1:0] t,
                          input logic [TW-1:0] tg, input int abort_kind, input int abort_at);
    int n;
    n = nbytes(t);
    chk("ld_rdy_idle", 32'(lb_rdy), 32'd1);
    lb_en = 1'b1; lb_addr = a; lb_type = t; lb_dest = tg;
    tick();
    lb_en = 1'b0;
    chk("ld_prev_pulse_clear", 32'({rob_fin, lb_fin}), 32'd0);
    for (int c = 1; c <= n + 1; c++) begin
      if (abort_kind != 0 && c == abort_at) begin
        if (abort_kind == 1) begin
          flush = 1'b1;
          tick();
          flush = 1'b0;
          chk("flush_idle", 32'(lb_rdy), 32'd1);
          chk("flush_wr", 32'(mem_wr), 32'd0);
        end else begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          chk("rst_rdy", 32'({rob_rdy, lb_rdy}), 32'd3);
          chk("rst_pulses", 32'({rob_fin, lb_fin}), 32'd0);
          chk("rst_wr", 32'(mem_wr), 32'd0);
          chk("rst_a", mem_a, 32'd0);
          chk("rst_dout", 32'(mem_dout), 32'd0);
          chk("rst_val", lb_val, 32'd0);
          chk("rst_dest", 32'(lb_dest_o), 32'd0);
        end
        repeat (4) begin
          tick();
          chk("abort_no_fin", 32'(lb_fin), 32'd0);
        end
        return;
      end
      if (c <= n) begin
        chk("ld_addr", mem_a, a + 32'(c - 1));
        chk("ld_wr0", 32'(mem_wr), 32'd0);
      end
      chk("ld_no_fin", 32'(lb_fin), 32'd0);
      chk("ld_busy", 32'(lb_rdy), 32'd0);
      tick();
    end
    chk("ld_fin", 32'(lb_fin), 32'd1);
    chk("ld_val", lb_val, exp_load(a, t));
    chk("ld_tag", 32'(lb_dest_o), 32'(tg));
    chk("ld_fin_rdy", 32'(lb_rdy), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [`INST_TYPE_WIDTH-1:0] st_types [3];
    logic [`INST_TYPE_WIDTH-1:0] ld_types [5];
    st_types = '{`SB, `SH, `SW};
    ld_types = '{`LB, `LH, `LW, `LBU, `LHU};

    repeat (2) tick();
    rst = 1'b0;
    chk("reset_rdy", 32'({rob_rdy, lb_rdy}), 32'd3);
    chk("reset_pulses", 32'({rob_fin, lb_fin}), 32'd0);
    chk("reset_wr", 32'(mem_wr), 32'd0);
    chk("reset_a", mem_a, 32'd0);
    chk("reset_dout", 32'(mem_dout), 32'd0);
    chk("reset_val", lb_val, 32'd0);
    chk("reset_dest", 32'(lb_dest_o), 32'd0);

    // Word store, then read back.
    store_run(32'h100, 32'hDEADBEEF, `SW, -1);
    tick();
    load_run(32'h100, `LW, 5'd3, 0, 0);

    // Sign / zero extension.
    set_byte(32'h20, 8'h80);
    load_run(32'h20, `LB, 5'd7, 0, 0);
    load_run(32'h20, `LBU, 5'd8, 0, 0);
    set_byte(32'h20, 8'h34);
    set_byte(32'h21, 8'h12);
    load_run(32'h20, `LHU, 5'd9, 0, 0);
    set_byte(32'h21, 8'hF2);
    load_run(32'h20, `LH, 5'd10, 0, 0);

    // Store has priority; load buffer holds its request throughout.
    lb_en = 1'b1; lb_addr = 32'h40; lb_type = `LW; lb_dest = 5'd17;
    store_run(32'h40, 32'h8765_4321, `SB, -1);
    load_run(32'h40, `LW, 5'd17, 0, 0);

    // Flush mid-load, then a halfword store.
    tick();
    load_run(32'h60, `LW, 5'd4, 1, 3);
    store_run(32'h62, 32'h0000_A55A, `SH, -1);
    tick();
    load_run(32'h62, `LHU, 5'd5, 0, 0);

    // Flush in IDLE blocks a simultaneous load.
    tick();
    lb_en = 1'b1; lb_addr = 32'h70; lb_type = `LB; flush = 1'b1;
    tick();
    lb_en = 1'b0; flush = 1'b0;
    chk("idle_flush_ignored", 32'(lb_rdy), 32'd1);

    // rdy_in freeze mid-store.
    store_run(32'h200, 32'h1122_3344, `SW, 1);
    tick();
    load_run(32'h200, `LW, 5'd6, 0, 0);

    // Reset mid-load.
    tick();
    load_run(32'h100, `LW, 5'd12, 2, 2);

    // Address wrap across 0xFFFFFFFF.
    store_run(32'hFFFF_FFFE, 32'hCAFE_F00D, `SW, -1);
    tick();
    load_run(32'hFFFF_FFFE, `LW, 5'd13, 0, 0);

`ifdef MEMCTRL_IO_STALL_EN
    tick();
    rob_en = 1'b1; rob_addr = 32'h30004; rob_wdata = 32'h0000_005C; rob_type = `SB;
    io_full = 1'b1;
    tick();
    rob_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("io_stall_wr0", 32'(mem_wr), 32'd0);
      chk("io_stall_no_fin", 32'(rob_fin), 32'd0);
      if (i == 4) io_full = 1'b0;
      else tick();
    end
    tick();
    chk("io_resume_wr", 32'(mem_wr), 32'd1);
    chk("io_resume_addr", mem_a, 32'h30004);
    chk("io_resume_byte", 32'(mem_dout), 32'h5C);
    tick();
    chk("io_fin", 32'(rob_fin), 32'd1);
    model[32'h30004] = 8'h5C;
`else
    tick();
    io_full = 1'b1;
    store_run(32'h30004, 32'h0000_005C, `SB, -1);
    io_full = 1'b0;
`endif
    tick();
    load_run(32'h30004, `LBU, 5'd14, 0, 0);

    // Randomized mix against the memory model.
    for (int it = 0; it < 40; it++) begin
      logic [31:0] ra;
      ra = 32'h300 + 32'($urandom_range(0, 23));
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 1) == 1)
        store_run(ra, $urandom, st_types[$urandom_range(0, 2)], -1);
      else
        load_run(ra, ld_types[$urandom_range(0, 4)], 5'($urandom_range(0, 31)), 0, 0);
    end
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller directly downstream of the reorder buffer's store-commit port. It also serves load requests from the load buffer.
- Accepts one committed store (from ROB) or one load (from load buffer) at a time. It drives the 8-bit single-port RAM one byte per cycle, little-endian, and returns a finish pulse plus, for loads, the extended 32-bit value with its ROB tag.
- Sits between ROB/load buffer and the top-level RAM pins.

Parameters:
ROB_TAG_W, 5, width of ROB tag carried with loads (matches `ROB_WIDTH)
IO_HI_BITS, 2'b11, value of addr[17:16] that marks the memory-mapped IO window

Ports:
clk_in  input  1  clock
rst_in  input  1  reset
rdy_in  input  1  global ready; low freezes all state
flush_in  input  1  misprediction flush; aborts an in-flight load
rob_en_in  input  1  store request, valid when rob_rdy_out=1 and rob_finish_out=0
rob_address_in  input  32  store byte address
rob_wdata_in  input  32  store data
rob_inst_type_in  input  `INST_TYPE_WIDTH  `SB/`SH/`SW
rob_rdy_out  output  1  controller idle, can accept
rob_finish_out  output  1  one-cycle pulse: store fully written
lbuffer_en_in  input  1  load request
lbuffer_address_in  input  32  load byte address
lbuffer_inst_type_in  input  `INST_TYPE_WIDTH  `LB/`LH/`LW/`LBU/`LHU
lbuffer_dest_in  input  ROB_TAG_W  ROB tag of load
lbuffer_rdy_out  output  1  controller can accept a load
lbuffer_finish_out  output  1  one-cycle pulse: load value valid
lbuffer_dest_out  output  ROB_TAG_W  tag of finished load
lbuffer_value_out  output  32  extended load data
mem_din_in  input  8  RAM read byte (1-cycle read latency)
mem_dout_out  output  8  RAM write byte
mem_a_out  output  32  RAM byte address
mem_wr_out  output  1  1=write, 0=read
io_buffer_full_in  input  1  UART output buffer full

Behaviour:
- Interface: one clock (clk_in); reset rst_in is synchronous, active-high. All outputs are registered except rob_rdy_out and lbuffer_rdy_out, which are combinational: (state==IDLE).
- Reset values: state=IDLE; all pulses 0; mem_wr_out=0; mem_a_out=0; mem_dout_out=0; lbuffer_value_out=0; lbuffer_dest_out=0.
- Reset has priority over rdy_in. Reset mid-operation abandons the transfer with no finish pulse.
- rdy_in=0: every register holds, including mem_wr_out.
- States: IDLE, STORE, LOAD.
- Size decode: N = 1/2/4 bytes for B/H/W; byte counter is 2 bits.
- IDLE acceptance:
  - rob_en_in has priority over lbuffer_en_in when both are high; the load is not latched and the load buffer must hold its request.
  - An accepted request latches address, data/type/tag and clears the counter.
- STORE (accepted at cycle T): byte k is presented at T+1+k with mem_a_out = addr+k, mem_dout_out = wdata[8k+7:8k], mem_wr_out=1.
  - Address addition is 32-bit and wraps.
  - After the last byte, return to IDLE with mem_wr_out=0 and rob_finish_out=1 visible at T+N+1.
  - Examples: SB finishes at T+2, SW at T+5.
- LOAD (accepted at T): address addr+k is presented at T+1+k with mem_wr_out=0. mem_din_in is sampled at T+2+k into byte lane k.
  - lbuffer_finish_out=1 with value and tag visible at T+N+2 (LW: T+6). State returns to IDLE the same cycle.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- flush_in=1:
  - In LOAD: go to IDLE immediately, no finish pulse, mem_wr_out=0.
  - In IDLE: a simultaneous lbuffer_en_in is ignored.
  - STORE is never aborted, because the store is already committed.
- Finish pulses last exactly one cycle. rob_rdy_out is already 1 in the finish cycle; the ROB's !finish guard prevents double issue.
- No alignment requirement; misaligned halfwords/words are handled bytewise.

Optional Feature:
- Macro: MEMCTRL_IO_STALL_EN.
- Defined: in STORE, if addr[17:16]==IO_HI_BITS and io_buffer_full_in=1, the next byte is not issued. mem_wr_out is driven 0, the counter holds, and finish is delayed by the stall cycles. The write resumes the cycle after io_buffer_full_in falls.
- Undefined: io_buffer_full_in is ignored and stores never stall.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF at T -> writes 0xEF@0x100 (T+1), 0xBE, 0xAD, 0xDE@0x103 (T+4); rob_finish_out at T+5; rob_rdy_out low T+1..T+4.
- LB addr=0x20, RAM byte 0x80 -> lbuffer_value_out=0xFFFFFF80 at T+3. LBU same -> 0x00000080. LHU 0x20..21=0x34,0x12 -> 0x00001234 at T+4 with the correct tag.
- rob_en_in and lbuffer_en_in both high in IDLE -> store served first. Load accepted only when re-presented after rob_finish_out; no load finish during the store.
- LW in flight, flush_in at T+3 -> IDLE at T+4, no lbuffer_finish_out. Subsequent SH completes normally at T'+3.
- rdy_in low for 3 cycles mid-SW -> byte sequence unchanged, finish delayed by exactly 3. rst_in mid-LW -> IDLE, all outputs at reset values, no pulse.
- MEMCTRL_IO_STALL_EN defined, SB to 0x30004 with io_buffer_full_in high for 4 cycles -> mem_wr_out stays 0 during those cycles. Write occurs the cycle after full drops; finish one cycle later.
